// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the memory line port between the I-cache and D-cache miss paths
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_grant_d;
    logic              grant_i;
    logic              grant_d;
    logic              serving;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              rd_q;
    logic              wr_q;

    // On a tie, the requester that was not granted last time wins.
    assign grant_d = (state == IDLE) && (d_read || d_write) && (!i_read || !last_grant_d);
    assign grant_i = (state == IDLE) && i_read && !grant_d;
    assign serving = (state == SERVE_I) || (state == SERVE_D);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx = SERVE_D;
                end else if (grant_i) begin
                    state_nx = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_nx = RELEASE;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        if (serving) begin
            mem_read  = rd_q;
            mem_write = wr_q;
        end
        if (state == SERVE_I) begin
            i_resp = mem_resp;
        end
        if (state == SERVE_D) begin
            d_resp = mem_resp;
        end
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Request fields are captured once at grant so the adaptor sees a stable request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            rd_q         <= !d_write;
            wr_q         <= d_write;
            last_grant_d <= 1'b1;
        end else if (grant_i) begin
            addr_q       <= i_address;
            wdata_q      <= '0;
            rd_q         <= 1'b1;
            wr_q         <= 1'b0;
            last_grant_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_read = 1'b0;
    logic [31:0]  i_address = '0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_address = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_resp = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } mem_txn_t;

    typedef struct {
        int           port;
        logic [255:0] rdata;
    } resp_t;

    mem_txn_t exp_mem[$];
    resp_t    exp_resp[$];

    int checks = 0;
    int failures = 0;
    int proto_errs = 0;
    int lg = 0;
    int lat_fixed = 0;
    bit fixed_rdata_en = 1'b0;
    bit spur_req = 1'b0;
    logic [255:0] fixed_rdata = {32{8'hA5}};

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory side: checks each granted request against the predicted grant order, then answers it.
    mem_txn_t     cur;
    bit           busy = 1'b0;
    int           cnt = 0;
    logic [255:0] rline;
    bit           nr;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0;
            end else if (mem_resp) begin
                busy = 1'b0;
            end else if (busy) begin
                chk("hold_rd", mem_read, cur.rd);
                chk("hold_wr", mem_write, cur.wr);
                chk("hold_addr", mem_address, cur.addr);
                if (cur.wr) chk("hold_wdata", mem_wdata, cur.wdata);
            end else if (mem_read || mem_write) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant addr=%0h", mem_address);
                    cur = '{2, mem_read, mem_write, mem_address, mem_wdata};
                end else begin
                    cur = exp_mem.pop_front();
                    chk("grant_addr", mem_address, cur.addr);
                    chk("grant_rd", mem_read, cur.rd);
                    chk("grant_wr", mem_write, cur.wr);
                    if (cur.wr) chk("grant_wdata", mem_wdata, cur.wdata);
                end
                busy = 1'b1;
                cnt = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6));
            end
            @(posedge clk);
            #1;
            nr = 1'b0;
            rline = (fixed_rdata_en) ? fixed_rdata : rand_line();
            if (rst_n) begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        nr = 1'b1;
                        exp_resp.push_back('{cur.port, rline});
                    end
                end else if (spur_req) begin
                    spur_req = 1'b0;
                    nr = 1'b1;
                    exp_resp.push_back('{2, rline});
                end
            end
            mem_resp  = nr;
            mem_rdata = nr ? rline : rand_line();
        end
    end

    resp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (mem_resp || i_resp || d_resp)) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp i_resp=%0b d_resp=%0b", i_resp, d_resp);
                end else begin
                    e = exp_resp.pop_front();
                    chk("i_resp", i_resp, (e.port == 0));
                    chk("d_resp", d_resp, (e.port == 1));
                    if (e.port != 2) begin
                        chk("i_rdata", i_rdata, e.rdata);
                        chk("d_rdata", d_rdata, e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && d_read && d_write) begin
                proto_errs++;
                $display("protocol error: d_read and d_write both high");
            end
        end
    end

    task automatic wait_resp(input int port, input int hold);
        int  t = 0;
        bit  got = 1'b0;
        while (!got && t < 300) begin
            @(negedge clk);
            t++;
            if ((port == 0) ? i_resp : d_resp) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout port=%0d", port);
        end
        repeat (hold + 1) @(posedge clk);
        #1;
        if (port == 0) begin
            i_read = 1'b0;
        end else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    task automatic run_round(input bit ien, input bit den, input bit dwr, input bit dboth,
                             input bit flip, input bit chk_lat, input int hold_i, input int hold_d,
                             input logic [31:0] ia, input logic [31:0] da, input logic [255:0] dw);
        mem_txn_t ti;
        mem_txn_t td;
        ti = '{0, 1'b1, 1'b0, ia, '0};
        td = '{1, !(dwr || dboth), (dwr || dboth), da, dw};
        if (ien && den) begin
            if (lg == 0) begin
                exp_mem.push_back(td);
                exp_mem.push_back(ti);
                lg = 0;
            end else begin
                exp_mem.push_back(ti);
                exp_mem.push_back(td);
                lg = 1;
            end
        end else if (ien) begin
            exp_mem.push_back(ti);
            lg = 0;
        end else if (den) begin
            exp_mem.push_back(td);
            lg = 1;
        end
        @(posedge clk);
        #1;
        i_read    = ien;
        i_address = ia;
        d_read    = den && (!dwr || dboth);
        d_write   = den && (dwr || dboth);
        d_address = da;
        d_wdata   = dw;
        fork
            begin
                if (ien) wait_resp(0, hold_i);
            end
            begin
                if (den) wait_resp(1, hold_d);
            end
            begin
                if (chk_lat) begin
                    @(negedge clk);
                    chk("strobe_before_grant", mem_read || mem_write, 1'b0);
                    @(negedge clk);
                    chk("strobe_after_grant", mem_read || mem_write, 1'b1);
                end
            end
            begin
                if (flip) begin
                    int t = 0;
                    while (!mem_write && t < 50) begin
                        @(negedge clk);
                        t++;
                    end
                    @(posedge clk);
                    #1;
                    d_wdata   = ~d_wdata;
                    d_address = d_address ^ 32'h0000_FFF0;
                end
            end
        join
        repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        lg = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_resps", {i_resp, d_resp}, 2'b00);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    mem_txn_t trs;
    initial begin
        int t;
        do_reset();

        lat_fixed = 5;
        fixed_rdata_en = 1'b1;
        run_round(1, 0, 0, 0, 0, 1, 0, 0, 32'h0000_1000, 32'h0, '0);
        fixed_rdata_en = 1'b0;

        run_round(0, 1, 1, 0, 1, 1, 0, 0, 32'h0, 32'h8000_0040, {8{32'h1234_5678}});

        do_reset();
        lat_fixed = 0;
        run_round(1, 1, 0, 0, 0, 1, 0, 0, 32'h0000_2000, 32'h0000_3000, '0);
        run_round(1, 1, 0, 0, 0, 1, 0, 0, 32'h0000_2040, 32'h0000_3040, '0);

        lat_fixed = 20;
        trs = '{1, 1'b1, 1'b0, 32'h0000_4000, '0};
        exp_mem.push_back(trs);
        @(posedge clk);
        #1;
        d_read = 1'b1;
        d_address = 32'h0000_4000;
        t = 0;
        while (!mem_read && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rst_test_granted", mem_read, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        lg = 0;
        #1;
        chk("async_rst_read", mem_read, 1'b0);
        chk("async_rst_write", mem_write, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_d_resp", d_resp, 1'b0);
        end
        lat_fixed = 3;
        exp_mem.push_back(trs);
        lg = 1;
        rst_n = 1'b1;
        wait_resp(1, 0);
        repeat (2) @(posedge clk);

        @(negedge clk);
        spur_req = 1'b1;
        repeat (4) @(negedge clk);
        lat_fixed = 0;
        run_round(1, 0, 0, 0, 0, 1, 1, 0, 32'h0000_5000, 32'h0, '0);
        run_round(0, 1, 1, 0, 0, 1, 0, 1, 32'h0, 32'h0000_6000, rand_line());

        run_round(0, 1, 0, 1, 0, 1, 0, 0, 32'h0, 32'h0000_7000, rand_line());
        checks++;
        if (proto_errs == 0) begin
            failures++;
            $display("FAIL protocol_flag actual=0 required=nonzero");
        end

        for (int r = 0; r < 30; r++) begin
            int sel;
            sel = $urandom_range(1, 3);
            run_round(sel[0], sel[1], 1'($urandom_range(0, 1)), 0, 0, 1,
                      $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom, $urandom, rand_line());
        end

        repeat (5) @(negedge clk);
        chk("exp_mem_drained", exp_mem.size(), 0);
        chk("exp_resp_drained", exp_resp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
